// File: rtl/alu_control_seq.sv
// ---------------------------------------------------------------------------
// alu_control_seq
//
// Registered, handshaked ALU control decoder. Decodes a 3-bit ALU op plus a
// 6-bit funct field into an ALU control code and hands it to the datapath
// through a valid/ready pair. Multiply and divide are held in an iteration
// phase for MC_CYCLES cycles, strobing iter_en, before the code is presented.
//
// Parameters:
//   CTRL_W    width of ctrl_out (>= 5); codes are zero-extended, the illegal
//             code is all ones
//   MC_CYCLES iteration cycles for mult/div (>= 2)
//   CNT_W     width of iter_cnt (2**CNT_W > MC_CYCLES)
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready input handshake carrying alu_op and funct
//   alu_op, funct     instruction fields from the main control unit
//   out_valid/out_ready output handshake carrying the decode
//   ctrl_out          decoded ALU control code
//   multi_cycle       decode is mult or div
//   iter_en, iter_cnt iteration strobe and remaining-iteration count
//   illegal           decode is unsupported (qualified by out_valid)
// ---------------------------------------------------------------------------
module alu_control_seq #(
    parameter int CTRL_W    = 5,
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_op,
    input  logic [5:0]        funct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              multi_cycle,
    output logic              iter_en,
    output logic [CNT_W-1:0]  iter_cnt,
    output logic              illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [4:0] CODE_ADD  = 5'b00001;
    localparam logic [4:0] CODE_SUB  = 5'b00010;
    localparam logic [4:0] CODE_AND  = 5'b00011;
    localparam logic [4:0] CODE_OR   = 5'b00100;
    localparam logic [4:0] CODE_SLT  = 5'b00101;
    localparam logic [4:0] CODE_SLL  = 5'b00110;
    localparam logic [4:0] CODE_SRL  = 5'b00111;
    localparam logic [4:0] CODE_MULT = 5'b01000;
    localparam logic [4:0] CODE_DIV  = 5'b01001;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state, state_next;
    logic [CTRL_W-1:0]  ctrl_reg, ctrl_next;
    logic               mc_reg, mc_next;
    logic               ill_reg, ill_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic [4:0]         dec_code;
    logic               dec_mc;
    logic               dec_ill;
    logic [CTRL_W-1:0]  dec_ctrl;
    logic               accept;

    // Pure decode of the current input fields; only used on an accept.
    always_comb begin
        dec_code = 5'b00000;
        dec_mc   = 1'b0;
        dec_ill  = 1'b0;
        case (alu_op)
            3'b000: dec_code = CODE_ADD;
            3'b001: dec_code = CODE_SUB;
            3'b011: dec_code = CODE_AND;
            3'b100: dec_code = CODE_OR;
            3'b101: dec_code = CODE_SLT;
            3'b010: begin
                case (funct)
                    6'b100000: dec_code = CODE_ADD;
                    6'b100010: dec_code = CODE_SUB;
                    6'b100100: dec_code = CODE_AND;
                    6'b100101: dec_code = CODE_OR;
                    6'b101010: dec_code = CODE_SLT;
                    6'b000000: dec_code = CODE_SLL;
                    6'b000010: dec_code = CODE_SRL;
                    6'b011000: begin
                        dec_code = CODE_MULT;
                        dec_mc   = 1'b1;
                    end
                    6'b011010: begin
                        dec_code = CODE_DIV;
                        dec_mc   = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Illegal decodes present all ones regardless of CTRL_W.
    assign dec_ctrl = dec_ill ? {CTRL_W{1'b1}} : CTRL_W'(dec_code);

    // in_ready looks through to out_ready in OUT so a result can be retired
    // and replaced in the same cycle.
    assign in_ready = (state == IDLE) || ((state == OUT) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next = state;
        ctrl_next  = ctrl_reg;
        mc_next    = mc_reg;
        ill_next   = ill_reg;
        cnt_next   = cnt_reg;
        case (state)
            IDLE, OUT: begin
                if (accept) begin
                    ctrl_next = dec_ctrl;
                    mc_next   = dec_mc;
                    ill_next  = dec_ill;
                    if (dec_mc) begin
                        state_next = ITER;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        state_next = OUT;
                        cnt_next   = '0;
                    end
                end else if ((state == OUT) && out_ready) begin
                    state_next = IDLE;
                end
            end
            ITER: begin
                // The count reaches zero exactly as the result is presented.
                if (cnt_reg == CNT_ONE) begin
                    state_next = OUT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ctrl_reg <= '0;
            mc_reg   <= 1'b0;
            ill_reg  <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            state    <= state_next;
            ctrl_reg <= ctrl_next;
            mc_reg   <= mc_next;
            ill_reg  <= ill_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign out_valid   = (state == OUT);
    assign iter_en     = (state == ITER);
    assign iter_cnt    = cnt_reg;
    assign ctrl_out    = ctrl_reg;
    assign multi_cycle = mc_reg;
    assign illegal     = ill_reg;

endmodule

// File: tb/tb_alu_control_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_control_seq
//
// Self-checking bench for alu_control_seq with default parameters. A table of
// single-cycle decodes is streamed back-to-back; multi-cycle, backpressure
// and mid-iteration reset are covered by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_alu_control_seq;

    localparam int CTRL_W    = 5;
    localparam int MC_CYCLES = 4;
    localparam int CNT_W     = 3;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        alu_op;
    logic [5:0]        funct;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] ctrl_out;
    logic              multi_cycle;
    logic              iter_en;
    logic [CNT_W-1:0]  iter_cnt;
    logic              illegal;

    int vec_count;
    int miscompares;

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic [4:0] exp_ctrl;
        logic       exp_ill;
    } vec_t;

    localparam int NUM_VECS = 16;
    vec_t vecs [NUM_VECS];

    alu_control_seq #(
        .CTRL_W(CTRL_W),
        .MC_CYCLES(MC_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .alu_op(alu_op),
        .funct(funct),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ctrl_out(ctrl_out),
        .multi_cycle(multi_cycle),
        .iter_en(iter_en),
        .iter_cnt(iter_cnt),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [5:0] fn);
        in_valid = v;
        alu_op   = op;
        funct    = fn;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " out_valid"}, 32'(out_valid), 0);
        checkOutput({tag, " ctrl_out"}, 32'(ctrl_out), 0);
        checkOutput({tag, " multi_cycle"}, 32'(multi_cycle), 0);
        checkOutput({tag, " iter_en"}, 32'(iter_en), 0);
        checkOutput({tag, " iter_cnt"}, 32'(iter_cnt), 0);
        checkOutput({tag, " illegal"}, 32'(illegal), 0);
    endtask

    // Starts from IDLE with out_ready=1; ends back in IDLE.
    task automatic runMulti(input string tag, input logic [5:0] fn, input logic [4:0] code);
        applyStimulus(1'b1, 3'b010, fn);
        checkOutput({tag, " in_ready idle"}, 32'(in_ready), 1);
        tick();
        applyStimulus(1'b1, 3'b000, 6'b100000);
        for (int i = 0; i < MC_CYCLES; i++) begin
            checkOutput({tag, " in_ready iter"}, 32'(in_ready), 0);
            checkOutput({tag, " iter_en"}, 32'(iter_en), 1);
            checkOutput({tag, " iter_cnt"}, 32'(iter_cnt), 32'(MC_CYCLES - i));
            checkOutput({tag, " out_valid iter"}, 32'(out_valid), 0);
            checkOutput({tag, " ctrl_out iter"}, 32'(ctrl_out), 32'(code));
            tick();
        end
        applyStimulus(1'b0, 3'b000, 6'b000000);
        checkOutput({tag, " out_valid"}, 32'(out_valid), 1);
        checkOutput({tag, " ctrl_out"}, 32'(ctrl_out), 32'(code));
        checkOutput({tag, " multi_cycle"}, 32'(multi_cycle), 1);
        checkOutput({tag, " illegal"}, 32'(illegal), 0);
        checkOutput({tag, " iter_en out"}, 32'(iter_en), 0);
        checkOutput({tag, " iter_cnt out"}, 32'(iter_cnt), 0);
        tick();
        checkOutput({tag, " out_valid retired"}, 32'(out_valid), 0);
    endtask

    initial begin
        vec_count   = 0;
        miscompares = 0;

        vecs[0]  = '{3'b001, 6'b010101, 5'b00010, 1'b0};
        vecs[1]  = '{3'b000, 6'b010101, 5'b00001, 1'b0};
        vecs[2]  = '{3'b010, 6'b100000, 5'b00001, 1'b0};
        vecs[3]  = '{3'b010, 6'b100010, 5'b00010, 1'b0};
        vecs[4]  = '{3'b010, 6'b100100, 5'b00011, 1'b0};
        vecs[5]  = '{3'b010, 6'b100101, 5'b00100, 1'b0};
        vecs[6]  = '{3'b010, 6'b101010, 5'b00101, 1'b0};
        vecs[7]  = '{3'b010, 6'b000000, 5'b00110, 1'b0};
        vecs[8]  = '{3'b010, 6'b000010, 5'b00111, 1'b0};
        vecs[9]  = '{3'b011, 6'b011000, 5'b00011, 1'b0};
        vecs[10] = '{3'b100, 6'b111111, 5'b00100, 1'b0};
        vecs[11] = '{3'b101, 6'b000000, 5'b00101, 1'b0};
        vecs[12] = '{3'b010, 6'b111111, 5'b11111, 1'b1};
        vecs[13] = '{3'b111, 6'b100000, 5'b11111, 1'b1};
        vecs[14] = '{3'b110, 6'b011000, 5'b11111, 1'b1};
        vecs[15] = '{3'b010, 6'b000001, 5'b11111, 1'b1};

        rst       = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b0, 3'b000, 6'b000000);
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b0;
        #1;
        checkOutput("in_ready after reset", 32'(in_ready), 1);

        // Back-to-back stream: each accept shows up one cycle later.
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(1'b1, vecs[i].op, vecs[i].fn);
            checkOutput("stream in_ready", 32'(in_ready), 1);
            tick();
            checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 1);
            checkOutput($sformatf("vec%0d ctrl_out", i), 32'(ctrl_out), 32'(vecs[i].exp_ctrl));
            checkOutput($sformatf("vec%0d illegal", i), 32'(illegal), 32'(vecs[i].exp_ill));
            checkOutput($sformatf("vec%0d multi_cycle", i), 32'(multi_cycle), 0);
            checkOutput($sformatf("vec%0d iter_en", i), 32'(iter_en), 0);
        end
        applyStimulus(1'b0, 3'b000, 6'b000000);
        tick();
        checkOutput("stream drained out_valid", 32'(out_valid), 0);
        checkOutput("stream drained in_ready", 32'(in_ready), 1);

        runMulti("mult", 6'b011000, 5'b01000);
        runMulti("div", 6'b011010, 5'b01001);

        // Backpressure: ADD held while a SUB waits at the input.
        out_ready = 1'b0;
        applyStimulus(1'b1, 3'b000, 6'b000000);
        tick();
        applyStimulus(1'b1, 3'b001, 6'b000000);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp out_valid", 32'(out_valid), 1);
            checkOutput("bp ctrl_out", 32'(ctrl_out), 32'(5'b00001));
            checkOutput("bp in_ready", 32'(in_ready), 0);
            tick();
        end
        checkOutput("bp held after stall", 32'(ctrl_out), 32'(5'b00001));
        out_ready = 1'b1;
        #1;
        checkOutput("bp in_ready released", 32'(in_ready), 1);
        tick();
        applyStimulus(1'b0, 3'b000, 6'b000000);
        checkOutput("bp new out_valid", 32'(out_valid), 1);
        checkOutput("bp new ctrl_out", 32'(ctrl_out), 32'(5'b00010));
        tick();
        checkOutput("bp retired out_valid", 32'(out_valid), 0);

        // Reset in the middle of a MULT iteration.
        applyStimulus(1'b1, 3'b010, 6'b011000);
        tick();
        applyStimulus(1'b0, 3'b000, 6'b000000);
        tick();
        tick();
        checkOutput("pre-reset iter_cnt", 32'(iter_cnt), 32'(MC_CYCLES - 2));
        rst = 1'b1;
        #1;
        checkAllZero("mid-iter reset");
        tick();
        rst = 1'b0;
        #1;
        checkOutput("post-reset in_ready", 32'(in_ready), 1);
        applyStimulus(1'b1, 3'b000, 6'b000000);
        tick();
        applyStimulus(1'b0, 3'b000, 6'b000000);
        checkOutput("post-reset out_valid", 32'(out_valid), 1);
        checkOutput("post-reset ctrl_out", 32'(ctrl_out), 32'(5'b00001));
        checkOutput("post-reset multi_cycle", 32'(multi_cycle), 0);
        checkOutput("post-reset iter_en", 32'(iter_en), 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
